uart_recv: RTL and testbench
============================

Name: uart_recv

Overview: UART receiver for 8N1 serial frames: start bit, 8 data bits sent LSB first, 1 stop bit, line idle high. It sits directly downstream of the UART transmitter, either in loopback or on the board RX pin. It synchronizes the asynchronous rxd line, finds the start edge, takes a 3-sample majority vote at mid-bit and delivers each byte with a one-cycle done strobe. Framing errors and glitches are flagged or rejected.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
UART_BPS, 9600, baud rate.
BPS_CNT, CLK_FREQ/UART_BPS (localparam), clocks per bit; must be at least 8.
HALF, BPS_CNT/2 (localparam), mid-bit count.

Ports:
sys_clk  in  1  system clock, rising edge.
sys_rst_n  in  1  asynchronous, active-low reset.
uart_rxd  in  1  serial input, asynchronous to sys_clk.
uart_data  out  8  last correctly framed byte; holds its value until the next good frame.
uart_done  out  1  one-cycle pulse when uart_data is updated.
uart_frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
uart_rx_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
- Reset values: uart_data=0, uart_done=0, uart_frame_err=0, uart_rx_busy=0, state=IDLE, counters=0.
- Synchronizer: 2-flop on uart_rxd, plus one more flop for edge detect (rx_prev).
  - All three flops reset to 0.
  - A start edge requires a synchronized high to be seen after reset, so a line held low through reset never starts a frame.
- Start detection: in IDLE, rx_prev=1 and rx_sync=0 is a start edge.
  - Next state is START and clk_cnt=0.
  - Define cycle T0 as the cycle in which the START state is entered.
- Bit timing: clk_cnt (16 bit) counts 0..BPS_CNT-1 in every bit state and wraps to 0 on each bit boundary.
- Sampling: rx_sync is sampled at clk_cnt = HALF-1, HALF and HALF+1.
  - The bit value is the majority of the 3 samples.
  - The vote is resolved at clk_cnt = HALF+1.
- States and transitions:
  - IDLE: on start edge -> START.
  - START: vote=1 at HALF+1 -> IDLE (glitch rejected, no output pulse). Otherwise at BPS_CNT-1 -> DATA with bit_cnt=0.
  - DATA: vote written into shift[bit_cnt]. At BPS_CNT-1: if bit_cnt=7 -> STOP, else bit_cnt+1.
  - STOP: vote resolved at HALF+1.
    - Vote=1: uart_data<=shift, uart_done=1 for exactly one cycle, -> IDLE in that same cycle.
    - Vote=0: uart_frame_err=1 for one cycle, uart_data unchanged, -> BREAK.
  - BREAK: stays until rx_sync=1, then -> IDLE. rx_busy stays high throughout.
- Early return to IDLE: leaving STOP at mid-stop-bit lets the receiver accept a transmitter whose stop bit is shortened to at least BPS_CNT*15/16. Back-to-back frames must not be lost.
- Latency: uart_done asserts at T0 + 9*BPS_CNT + HALF + 1 cycles, relative to the start edge in the synchronized domain. That is 3 more cycles relative to the uart_rxd pin.
- uart_done and uart_frame_err are never high together. Neither is ever high for more than one cycle.
- Reset mid-frame: everything returns to reset values immediately. No done or err pulse is produced for the partial frame.
- uart_data does not change at any time other than the uart_done cycle.

Test Plan:
- Use CLK_FREQ=160, UART_BPS=10, giving BPS_CNT=16 and HALF=8.
- Send frame 0x55 -> uart_done pulses once at T0+153, uart_data=0x55, rx_busy drops in the same cycle, frame_err stays 0.
- Low pulse of 3 cycles on an idle line -> no done and no err; rx_busy high for about 9 cycles then 0; uart_data unchanged.
- Frame 0xA3 with stop bit=0, then line returned high 40 cycles later -> frame_err pulses once, uart_data keeps its previous value (0x55), rx_busy stays high until 3 cycles after the line goes high.
- Back-to-back frames 0x00 then 0xFF, each stop bit shortened to 15 cycles -> two done pulses, data 0x00 then 0xFF.
- Frame 0x0F with a 1-cycle inverted glitch at clk_cnt=HALF of bit 2 -> majority vote rejects it, uart_data=0x0F.
- sys_rst_n pulsed low during bit 4 of a frame -> outputs return to 0 at once and no pulses follow. The remaining tail of the frame produces no done pulse: any falsely detected start is either rejected as a glitch or ends in frame_err. A clean 0x3C frame sent after that is received correctly.
- Loopback against the UART transmitter block at default parameters, bytes 0x00..0xFF -> all 256 received in order with no frame errors.

Source files
------------

// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchronizer, start-edge detect, 3-sample mid-bit majority vote.
// Latency: done/frame_err at T0 + 9*BPS_CNT + HALF + 1 (T0 = first START cycle); no backpressure, one-cycle strobes.
module uart_recv #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       uart_frame_err,
    output logic       uart_rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;

    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_PRE  = 16'(HALF - 1);
    localparam logic [15:0] CNT_MID  = 16'(HALF);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        samp_lo_q, samp_lo_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic vote;
    logic at_mid;
    logic at_last;

    // Decisions are taken one cycle early so the registered result lands exactly at HALF+1;
    // rx_meta_q is the value rx_sync_q will hold at HALF+1.
    assign vote    = (samp_lo_q & rx_sync_q) | (samp_lo_q & rx_meta_q) | (rx_sync_q & rx_meta_q);
    assign at_mid  = (clk_cnt_q == CNT_MID);
    assign at_last = (clk_cnt_q == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
            state_q   <= S_IDLE;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            samp_lo_q <= 1'b0;
            data_q    <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= uart_rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            samp_lo_q <= samp_lo_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = at_last ? 16'd0 : clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        samp_lo_d = (clk_cnt_q == CNT_PRE) ? rx_sync_q : samp_lo_q;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = 16'd0;
                bit_cnt_d = 3'd0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (at_mid && vote) begin
                    state_d   = S_IDLE;
                    clk_cnt_d = 16'd0;
                end else if (at_last) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (at_mid) begin
                    shift_d[bit_cnt_q] = vote;
                end
                if (at_last) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a shortened stop bit cannot swallow the next start edge.
                if (at_mid) begin
                    state_d   = vote ? S_IDLE : S_BRK;
                    clk_cnt_d = 16'd0;
                end
            end
            S_BRK: begin
                clk_cnt_d = 16'd0;
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = 16'd0;
            end
        endcase
    end

    always_comb begin
        done_d = 1'b0;
        err_d  = 1'b0;
        data_d = data_q;
        if (state_q == S_STOP && at_mid) begin
            if (vote) begin
                done_d = 1'b1;
                data_d = shift_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign uart_data      = data_q;
    assign uart_done      = done_q;
    assign uart_frame_err = err_q;
    assign uart_rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at BPS_CNT=16: table of single frames plus hand-built corner sequences.
// Line is driven on the falling clock edge, DUT outputs observed 1 time unit after the rising edge.
module tb_uart_recv;

    localparam int CLK_FREQ = 160;
    localparam int UART_BPS = 10;
    localparam int BPS      = 16;
    localparam int LAT      = 9 * BPS + BPS / 2 + 1;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       uart_frame_err;
    logic       uart_rx_busy;

    uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .uart_rxd      (uart_rxd),
        .uart_data     (uart_data),
        .uart_done     (uart_done),
        .uart_frame_err(uart_frame_err),
        .uart_rx_busy  (uart_rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int busy_rise_cyc = 0;
    int busy_fall_cyc = 0;
    int busy_rises = 0;
    int overlap = 0;
    int dbl_done = 0;
    int dbl_err = 0;
    int data_bad = 0;
    logic rst_window = 1'b1;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] data_q[$];

    int start_cyc = 0;
    int high_cyc = 0;

    always @(posedge sys_clk) begin
        #1;
        cyc = cyc + 1;
        if (uart_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            data_q.push_back(uart_data);
        end
        if (uart_frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (uart_done && uart_frame_err) overlap = overlap + 1;
        if (uart_done && prev_done) dbl_done = dbl_done + 1;
        if (uart_frame_err && prev_err) dbl_err = dbl_err + 1;
        if (uart_rx_busy && !prev_busy) begin
            busy_rise_cyc = cyc;
            busy_rises    = busy_rises + 1;
        end
        if (!uart_rx_busy && prev_busy) busy_fall_cyc = cyc;
        if (!rst_window && !uart_done && uart_data !== prev_data) data_bad = data_bad + 1;
        prev_done = uart_done;
        prev_err  = uart_frame_err;
        prev_busy = uart_rx_busy;
        prev_data = uart_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame bit b: 0 = start, 1..8 = data LSB first, 9 = stop (stop_len cycles).
    // glitch_bit inverts pin offset 9 of that data bit; rst_bit pulses reset inside that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                              input int glitch_bit, input int rst_bit);
        logic [9:0] bits;
        int len;
        bits = {stop_v, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            len = (b == 9) ? stop_len : BPS;
            for (int o = 0; o < len; o++) begin
                @(negedge sys_clk);
                uart_rxd = bits[b];
                if (b == 0 && o == 0) start_cyc = cyc;
                if (glitch_bit >= 0 && b == glitch_bit + 1 && o == 9) uart_rxd = ~bits[b];
                if (rst_bit >= 0 && b == rst_bit + 1 && o == 5) sys_rst_n = 1'b1;
                if (rst_bit >= 0 && b == rst_bit + 1 && o == 4) begin
                    rst_window = 1'b1;
                    sys_rst_n  = 1'b0;
                    #1;
                    check("rst_mid_data", 32'(uart_data), 32'h00);
                    check("rst_mid_done", 32'(uart_done), 32'h0);
                    check("rst_mid_err", 32'(uart_frame_err), 32'h0);
                    check("rst_mid_busy", 32'(uart_rx_busy), 32'h0);
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_v;
        int         stop_len;
        int         glitch_bit;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int d0;
        int e0;
        int base;

        tbl[0] = '{8'h55, 1'b1, 16, -1, 1, 0, 8'h55};
        tbl[1] = '{8'hA3, 1'b0, 40, -1, 0, 1, 8'h55};
        tbl[2] = '{8'h0F, 1'b1, 16,  2, 1, 0, 8'h0F};
        tbl[3] = '{8'h81, 1'b1, 16, -1, 1, 0, 8'h81};
        tbl[4] = '{8'h7E, 1'b1, 16,  0, 1, 0, 8'h7E};

        // Reset with the line held low: no frame may start once reset is released.
        sys_rst_n = 1'b0;
        uart_rxd  = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_data", 32'(uart_data), 32'h00);
        check("rst_done", 32'(uart_done), 32'h0);
        check("rst_err", 32'(uart_frame_err), 32'h0);
        check("rst_busy", 32'(uart_rx_busy), 32'h0);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("low_line_no_start", 32'(busy_rises), 32'd0);
        uart_rxd   = 1'b1;
        rst_window = 1'b0;
        repeat (10) @(negedge sys_clk);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(tbl[i].d, tbl[i].stop_v, tbl[i].stop_len, tbl[i].glitch_bit, -1);
            @(negedge sys_clk);
            uart_rxd = 1'b1;
            high_cyc = cyc;
            repeat (20) @(negedge sys_clk);
            check($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(tbl[i].exp_done));
            check($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
            check($sformatf("v%0d_data", i), 32'(uart_data), 32'(tbl[i].exp_data));
            check($sformatf("v%0d_start_lat", i), 32'(busy_rise_cyc - start_cyc), 32'd3);
            if (tbl[i].exp_done != 0) begin
                check($sformatf("v%0d_done_lat", i), 32'(done_cyc - busy_rise_cyc), 32'(LAT));
                check($sformatf("v%0d_busy_fall", i), 32'(busy_fall_cyc), 32'(done_cyc));
            end else begin
                check($sformatf("v%0d_err_lat", i), 32'(err_cyc - busy_rise_cyc), 32'(LAT));
                check($sformatf("v%0d_brk_fall", i), 32'(busy_fall_cyc - high_cyc), 32'd3);
            end
        end

        // Three-cycle low pulse on an idle line is rejected at mid start bit.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge sys_clk);
        uart_rxd  = 1'b0;
        start_cyc = cyc;
        repeat (3) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("pulse_start_lat", 32'(busy_rise_cyc - start_cyc), 32'd3);
        check("pulse_busy_len", 32'(busy_fall_cyc - busy_rise_cyc), 32'd9);
        check("pulse_done", 32'(done_cnt - d0), 32'd0);
        check("pulse_err", 32'(err_cnt - e0), 32'd0);
        check("pulse_data", 32'(uart_data), 32'h7E);

        // Back-to-back frames with 15-cycle stop bits.
        d0   = done_cnt;
        e0   = err_cnt;
        base = data_q.size();
        send_frame(8'h00, 1'b1, 15, -1, -1);
        send_frame(8'hFF, 1'b1, 15, -1, -1);
        @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_err", 32'(err_cnt - e0), 32'd0);
        if (data_q.size() == base + 2) begin
            check("b2b_first", 32'(data_q[base]), 32'h00);
            check("b2b_second", 32'(data_q[base + 1]), 32'hFF);
        end else begin
            check("b2b_count", 32'(data_q.size() - base), 32'd2);
        end

        // Reset pulse during data bit 4; the tail must not produce any strobe.
        send_frame(8'hF0, 1'b1, 16, -1, 4);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge sys_clk);
        uart_rxd   = 1'b1;
        rst_window = 1'b0;
        repeat (40) @(negedge sys_clk);
        check("tail_done", 32'(done_cnt - d0), 32'd0);
        check("tail_err", 32'(err_cnt - e0), 32'd0);
        check("tail_busy", 32'(uart_rx_busy), 32'h0);
        check("tail_data", 32'(uart_data), 32'h00);
        d0 = done_cnt;
        send_frame(8'h3C, 1'b1, 16, -1, -1);
        @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);
        check("post_rst_data", 32'(uart_data), 32'h3C);

        // Stream every byte value through, as a transmitter would in loopback.
        d0   = done_cnt;
        e0   = err_cnt;
        base = data_q.size();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1, 16, -1, -1);
        end
        @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("loop_done", 32'(done_cnt - d0), 32'd256);
        check("loop_err", 32'(err_cnt - e0), 32'd0);
        if (data_q.size() == base + 256) begin
            for (int i = 0; i < 256; i++) begin
                check($sformatf("loop_byte_%0d", i), 32'(data_q[base + i]), 32'(i));
            end
        end

        check("done_err_overlap", 32'(overlap), 32'd0);
        check("done_multi_cycle", 32'(dbl_done), 32'd0);
        check("err_multi_cycle", 32'(dbl_err), 32'd0);
        check("data_changed_without_done", 32'(data_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
